// File: rtl/ro_capture.sv
// Readout frame capture: aligns bus slots to the clk_8 frame
// reference and hands completed frames to a valid/ready consumer.
module ro_capture #(
  parameter int NSLOT       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_ext,
  input  logic               rstb,
  input  logic               clk_8,
  input  logic [1:0]         bus,
  input  logic               en,
  input  logic               clr,
  output logic [2*NSLOT-1:0] frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [3:0]         slot,
  output logic               overrun,
  output logic               sync_err
);

  localparam int FW  = 2 * NSLOT;
  localparam int ACW = $clog2(SYNC_STAGES + 2);
  localparam logic [3:0]     LAST = 4'(NSLOT - 1);
  localparam logic [ACW-1:0] ARM  = ACW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    CAPTURE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic [ACW-1:0]         r_arm;
  state_t                 r_state;
  logic [3:0]             r_slot;
  logic [FW-1:0]          r_buf;
  logic [FW-1:0]          r_frame;
  logic                   r_fv;
  logic                   r_ovr;
  logic                   r_serr;

  logic                   w_pulse;
  logic                   w_cap;
  logic                   w_cmpl;
  logic                   w_serr;
  logic                   w_drop;
  logic [FW-1:0]          w_word;

  // Synchronize clk_8; hold off pulses until the chain holds real samples
  always_ff @(posedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      r_sync <= '1;
      r_edge <= 1'b1;
      r_arm  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], clk_8};
      r_edge <= r_sync[SYNC_STAGES-1];
      if (r_arm != ARM)
        r_arm <= r_arm + ACW'(1);
    end
  end

  assign w_pulse = r_edge & ~r_sync[SYNC_STAGES-1]
                 & (r_arm == ARM);
  assign w_cap   = en & (r_state == CAPTURE);
  assign w_cmpl  = w_cap & (r_slot == LAST);
  assign w_serr  = w_cap & w_pulse & (r_slot != LAST);
  assign w_drop  = w_cmpl & r_fv & ~frame_ready;
  assign w_word  = {bus, r_buf[FW-3:0]};

  // Slot sequencer: frame alignment and per-slot sampling
  always_ff @(posedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_buf   <= '0;
    end else if (!en) begin
      r_state <= IDLE;
      r_slot  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= WAIT_SYNC;
        end
        WAIT_SYNC: begin
          if (w_pulse) begin
            r_buf[1:0] <= bus;
            r_slot     <= 4'd1;
            r_state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (w_pulse) begin
            r_buf[1:0] <= bus;
            r_slot     <= 4'd1;
          end else if (r_slot == LAST) begin
            r_slot  <= '0;
            r_state <= WAIT_SYNC;
          end else begin
            r_buf[{r_slot, 1'b0} +: 2] <= bus;
            r_slot <= r_slot + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_slot  <= '0;
        end
      endcase
    end
  end

  // Output holding register with valid/ready handoff
  always_ff @(posedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      r_frame <= '0;
      r_fv    <= 1'b0;
    end else if (w_cmpl) begin
      if (!r_fv || frame_ready) begin
        r_frame <= w_word;
        r_fv    <= 1'b1;
      end
    end else if (r_fv && frame_ready) begin
      r_fv <= 1'b0;
    end
  end

  // Sticky error flags; a new event beats a same-cycle clear
  always_ff @(posedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      r_ovr  <= 1'b0;
      r_serr <= 1'b0;
    end else begin
      if (w_drop)
        r_ovr <= 1'b1;
      else if (clr)
        r_ovr <= 1'b0;
      if (w_serr)
        r_serr <= 1'b1;
      else if (clr)
        r_serr <= 1'b0;
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_fv;
  assign slot        = r_slot;
  assign overrun     = r_ovr;
  assign sync_err    = r_serr;

endmodule

// File: tb/tb_ro_capture.sv
// Bench for ro_capture: directed frame scenarios plus random
// traffic, checked every cycle against a queue-based frame model.
module tb_ro_capture;

  localparam int NSLOT = 8;
  localparam int NS    = 2;
  localparam int FW    = 2 * NSLOT;

  logic          clk_ext = 1'b0;
  logic          rstb = 1'b0;
  logic          clk_8 = 1'b1;
  logic [1:0]    bus = 2'b00;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          frame_ready = 1'b0;
  logic [FW-1:0] frame;
  logic          frame_valid;
  logic [3:0]    slot;
  logic          overrun;
  logic          sync_err;

  ro_capture #(.NSLOT(NSLOT), .SYNC_STAGES(NS)) dut (
    .clk_ext    (clk_ext),
    .rstb       (rstb),
    .clk_8      (clk_8),
    .bus        (bus),
    .en         (en),
    .clr        (clr),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .slot       (slot),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  always #5 clk_ext = ~clk_ext;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rel = 0;
  int ph  = 4;
  logic alt = 1'b1;
  logic h8 [0:8191];

  logic          m_act;
  logic [1:0]    m_q [$];
  logic [FW-1:0] m_frame;
  logic          m_fv;
  logic          m_ovr;
  logic          m_serr;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_act   = 1'b0;
    m_q.delete();
    m_frame = '0;
    m_fv    = 1'b0;
    m_ovr   = 1'b0;
    m_serr  = 1'b0;
  endtask

  // Frame-level reference: a falling clk_8 edge seen NS cycles
  // later starts a frame; NSLOT collected slots make a word.
  task automatic m_step();
    logic pulse, cmpl, serr_ev, drop;
    logic [FW-1:0] w;
    pulse = 1'b0;
    if (cyc - NS - 1 >= rel)
      pulse = h8[cyc-NS-1] && !h8[cyc-NS];
    cmpl = 1'b0;
    serr_ev = 1'b0;
    w = '0;
    for (int k = 0; k < m_q.size(); k++)
      w[2*k +: 2] = m_q[k];
    if (!en) begin
      m_act = 1'b0;
      m_q.delete();
    end else if (!m_act) begin
      m_act = 1'b1;
    end else if (pulse) begin
      if (m_q.size() == NSLOT - 1) begin
        cmpl = 1'b1;
        w[2*(NSLOT-1) +: 2] = bus;
      end else if (m_q.size() > 0) begin
        serr_ev = 1'b1;
      end
      m_q.delete();
      m_q.push_back(bus);
    end else if (m_q.size() > 0) begin
      m_q.push_back(bus);
      if (m_q.size() == NSLOT) begin
        cmpl = 1'b1;
        w[2*(NSLOT-1) +: 2] = bus;
        m_q.delete();
      end
    end
    drop = cmpl && m_fv && !frame_ready;
    if (cmpl && (!m_fv || frame_ready)) begin
      m_frame = w;
      m_fv = 1'b1;
    end else if (!cmpl && m_fv && frame_ready) begin
      m_fv = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (serr_ev) m_serr = 1'b1;
    else if (clr) m_serr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_ext);
    h8[cyc] = clk_8;
    if (rstb) m_step();
    cyc++;
    #1;
    chk("frame", frame, m_frame);
    chk("frame_valid", frame_valid, m_fv);
    chk("overrun", overrun, m_ovr);
    chk("sync_err", sync_err, m_serr);
    chk("slot", slot, m_q.size());
  endtask

  task automatic drv();
    ph = (ph + 1) % NSLOT;
    clk_8 = (ph >= NSLOT / 2);
  endtask

  // mode 0: slot index mod 4, 1: alternating 01/10 frames, 2: random
  task automatic run(int n, int mode);
    for (int i = 0; i < n; i++) begin
      drv();
      case (mode)
        0: bus = 2'(((ph - NS + NSLOT) % NSLOT) % 4);
        1: begin
          if (ph == NS) alt = ~alt;
          bus = alt ? 2'b10 : 2'b01;
        end
        default: bus = 2'($urandom);
      endcase
      tick();
    end
  endtask

  task automatic wait_fv(string tag, int lim, int mode);
    int k;
    k = 0;
    while (!frame_valid && k < lim) begin
      run(1, mode);
      k++;
    end
    chk(tag, frame_valid, 1);
  endtask

  task automatic do_reset();
    #1;
    rstb = 1'b0;
    m_reset();
    #1;
    chk("rst_frame", frame, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_slot", slot, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_serr", sync_err, 0);
    tick();
    rstb = 1'b1;
    rel = cyc;
  endtask

  initial begin
    m_reset();
    clk_8 = 1'b1;
    repeat (3) tick();
    chk("rst_fv0", frame_valid, 0);
    chk("rst_frame0", frame, 0);
    rstb = 1'b1;
    rel = cyc;
    en = 1'b1;

    wait_fv("fv_first", 40, 0);
    chk("e4e4_first", frame, 16'hE4E4);
    frame_ready = 1'b1;
    run(1, 0);
    chk("fv_consumed", frame_valid, 0);

    en = 1'b0;
    while (ph != NS + 2) run(1, 0);
    alt = 1'b1;
    en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_fv("fv_alt", 20, 1);
      chk("alt_frame", frame, (f % 2) ? 16'hAAAA : 16'h5555);
      run(1, 1);
    end
    chk("alt_ovr", overrun, 0);
    chk("alt_serr", sync_err, 0);

    frame_ready = 1'b0;
    run(24, 2);
    chk("ovr_set", overrun, 1);
    frame_ready = 1'b1;
    clr = 1'b1;
    run(1, 2);
    clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    while (frame_valid || ph != 4) run(1, 0);
    ph = NSLOT - 1;
    run(1, 0);
    wait_fv("fv_resync", 20, 0);
    chk("serr_set", sync_err, 1);
    chk("resync_frame", frame, 16'hE4E4);
    clr = 1'b1;
    run(1, 0);
    clr = 1'b0;
    chk("serr_clr", sync_err, 0);

    while (ph != NS + 3) run(1, 0);
    en = 1'b0;
    run(3, 0);
    en = 1'b1;
    wait_fv("fv_after_en", 30, 0);
    chk("en_frame", frame, 16'hE4E4);

    while (ph != NS + 5) run(1, 0);
    do_reset();
    wait_fv("fv_after_rst", 40, 0);
    chk("rst_frame_e4", frame, 16'hE4E4);

    for (int i = 0; i < 800; i++) begin
      en = ($urandom % 40) != 0;
      frame_ready = $urandom % 2;
      clr = ($urandom % 25) == 0;
      if ($urandom % 60 == 0) ph = $urandom % NSLOT;
      if ($urandom % 300 == 0) do_reset();
      drv();
      bus = 2'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
